// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types for the PLL lock supervisor: FSM states, counter width, saturating increment.
package pll_sup_pkg;

   localparam int unsigned CNT_W = 8;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      RETRY,
      FAULT
   } sup_state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and downstream-reset signals of the lock supervisor, bundled as one interface.
interface pll_sup_if;
   import pll_sup_pkg::*;

   logic             pll_lock_in;
   logic             pll_reset;
   logic             sys_rst;
   logic             ready;
   logic             fault;
   logic [CNT_W-1:0] retry_cnt;
   logic [CNT_W-1:0] lock_lost_cnt;

   modport master (
      output pll_lock_in,
      input  pll_reset, sys_rst, ready, fault, retry_cnt, lock_lost_cnt
   );

   modport slave (
      input  pll_lock_in,
      output pll_reset, sys_rst, ready, fault, retry_cnt, lock_lost_cnt
   );
endinterface

// File: rtl/pll_lock_supervisor_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL LOCK into the board clock domain.
module lock_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses PLL reset, waits for stable lock, then releases system reset.
// Optional LOCK_LOSS_COUNT_EN keeps a saturating count of lock losses seen while running.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned PLL_RST_CYCLES = 27,
   parameter int unsigned LOCK_TIMEOUT   = 2700000,
   parameter int unsigned STABLE_CYCLES  = 27000,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input logic    clk,
   input logic    rst,
   pll_sup_if.slave sup
);

   localparam int unsigned TMR_MAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
   localparam int unsigned TMR_MAX  = (TMR_MAX0 > PLL_RST_CYCLES) ? TMR_MAX0 : PLL_RST_CYCLES;
   localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

   sup_state_e       state_q, state_d;
   logic [TMR_W-1:0] timer_q;
   logic             pll_reset_q, sys_rst_q, ready_q, fault_q;
   logic [CNT_W-1:0] retry_q;
   logic             lock_s;
   logic             lock_lost_c;

   lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (sup.pll_lock_in),
      .q_o (lock_s)
   );

   // Lock is checked before timeout so a late lock still wins.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PLL_RST:   if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lock_s)                                     state_d = STABLE;
            else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1))   state_d = RETRY;
         end
         STABLE: begin
            if (!lock_s)                                    state_d = WAIT_LOCK;
            else if (timer_q == TMR_W'(STABLE_CYCLES - 1))  state_d = RUN;
         end
         RUN:       if (!lock_s) state_d = PLL_RST;
         RETRY:     state_d = (retry_q == CNT_W'(MAX_RETRIES)) ? FAULT : PLL_RST;
         FAULT:     state_d = FAULT;
         default:   state_d = PLL_RST;
      endcase
   end

   assign lock_lost_c = (state_q == RUN) && (state_d == PLL_RST);

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PLL_RST;
         timer_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         retry_q     <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= (state_d != state_q) ? '0 : timer_q + TMR_W'(1);
         pll_reset_q <= (state_d == PLL_RST) || (state_d == FAULT);
         sys_rst_q   <= (state_d != RUN);
         ready_q     <= (state_d == RUN);
         fault_q     <= (state_d == FAULT);
         if ((state_q == RETRY) && (state_d == PLL_RST)) retry_q <= sat_inc(retry_q);
         else if (lock_lost_c)                           retry_q <= '0;
      end
   end

`ifdef LOCK_LOSS_COUNT_EN
   logic [CNT_W-1:0] lost_q;

   always_ff @(posedge clk) begin
      if (rst)              lost_q <= '0;
      else if (lock_lost_c) lost_q <= sat_inc(lost_q);
   end

   assign sup.lock_lost_cnt = lost_q;
`else
   assign sup.lock_lost_cnt = CNT_W'(0);
`endif

   assign sup.pll_reset = pll_reset_q;
   assign sup.sys_rst   = sys_rst_q;
   assign sup.ready     = ready_q;
   assign sup.fault     = fault_q;
   assign sup.retry_cnt = retry_q;

endmodule
